// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: a 2-entry elastic buffer carrying LANES writeback slots per bundle,
// with synchronous flush and a committed NZCV flag register updated at writeback.
module mem_wb_pipe #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned FLAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*REG_AW-1:0]    in_rd,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic [LANES-1:0]           in_regwrite,
    input  logic [LANES*FLAG_W-1:0]    in_flags,
    input  logic [LANES-1:0]           in_flagwrite,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*REG_AW-1:0]    out_rd,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic [LANES-1:0]           out_regwrite,
    output logic [LANES*FLAG_W-1:0]    out_flags,
    output logic [LANES-1:0]           out_flagwrite,
    output logic [FLAG_W-1:0]          arch_flags,
    output logic [1:0]                 count
);

    localparam int unsigned RdW    = LANES * REG_AW;
    localparam int unsigned DataW  = LANES * DATA_W;
    localparam int unsigned FlagsW = LANES * FLAG_W;
    localparam int unsigned EntryW = RdW + DataW + LANES + FlagsW + LANES;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } stateT;

    stateT              stateQ;
    logic [EntryW-1:0]  headQ;
    logic [EntryW-1:0]  tailQ;
    logic [FLAG_W-1:0]  archFlagsQ;

    logic [EntryW-1:0]  inEntry;
    logic [RdW-1:0]     headRd;
    logic [DataW-1:0]   headData;
    logic [LANES-1:0]   headRegwrite;
    logic [FlagsW-1:0]  headFlags;
    logic [LANES-1:0]   headFlagwrite;
    logic               accept;
    logic               consume;
    logic [FLAG_W-1:0]  archFlagsNext;

    assign inEntry = {in_rd, in_data, in_regwrite, in_flags, in_flagwrite};
    assign {headRd, headData, headRegwrite, headFlags, headFlagwrite} = headQ;

    always_comb begin
        count = 2'd0;
        unique case (stateQ)
            StEmpty: count = 2'd0;
            StOne:   count = 2'd1;
            StTwo:   count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    assign in_ready  = (count != 2'd2) & ~flush;
    assign out_valid = (count != 2'd0) & ~flush;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Payload is forced to zero whenever nothing is being presented.
    always_comb begin
        out_rd        = '0;
        out_data      = '0;
        out_regwrite  = '0;
        out_flags     = '0;
        out_flagwrite = '0;
        if (out_valid) begin
            out_rd        = headRd;
            out_data      = headData;
            out_regwrite  = headRegwrite;
            out_flags     = headFlags;
            out_flagwrite = headFlagwrite;
        end
    end

    // Ascending lane walk: the highest-indexed writing lane has the final say.
    always_comb begin
        archFlagsNext = archFlagsQ;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (out_flagwrite[i]) begin
                archFlagsNext = out_flags[i*FLAG_W +: FLAG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StEmpty;
            headQ      <= '0;
            tailQ      <= '0;
            archFlagsQ <= '0;
        end else if (flush) begin
            stateQ <= StEmpty;
        end else begin
            if (consume) begin
                archFlagsQ <= archFlagsNext;
            end
            unique case (stateQ)
                StEmpty: begin
                    if (accept) begin
                        headQ  <= inEntry;
                        stateQ <= StOne;
                    end
                end
                StOne: begin
                    if (accept && !consume) begin
                        tailQ  <= inEntry;
                        stateQ <= StTwo;
                    end else if (!accept && consume) begin
                        stateQ <= StEmpty;
                    end else if (accept && consume) begin
                        headQ <= inEntry;
                    end
                end
                StTwo: begin
                    if (consume) begin
                        headQ  <= tailQ;
                        stateQ <= StOne;
                    end
                end
                default: stateQ <= StEmpty;
            endcase
        end
    end

    assign arch_flags = archFlagsQ;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: driver queues accepted bundles, a negedge monitor checks
// handshakes, occupancy, head payload and the committed flag register against a queue model.
module tb_mem_wb_pipe;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned FLAG_W = 4;

    typedef struct packed {
        logic [LANES*REG_AW-1:0] rd;
        logic [LANES*DATA_W-1:0] data;
        logic [LANES-1:0]        rw;
        logic [LANES*FLAG_W-1:0] flags;
        logic [LANES-1:0]        fw;
    } bundleT;

    logic                    clk = 1'b0;
    logic                    reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES*REG_AW-1:0] in_rd, out_rd;
    logic [LANES*DATA_W-1:0] in_data, out_data;
    logic [LANES-1:0]        in_regwrite, out_regwrite, in_flagwrite, out_flagwrite;
    logic [LANES*FLAG_W-1:0] in_flags, out_flags;
    logic [FLAG_W-1:0]       arch_flags;
    logic [1:0]              count;

    mem_wb_pipe #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .FLAG_W(FLAG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .in_regwrite  (in_regwrite),
        .in_flags     (in_flags),
        .in_flagwrite (in_flagwrite),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_regwrite (out_regwrite),
        .out_flags    (out_flags),
        .out_flagwrite(out_flagwrite),
        .arch_flags   (arch_flags),
        .count        (count)
    );

    always #5 clk = ~clk;

    bundleT            q[$];
    int                total = 0;
    int                bad = 0;
    int                pushCnt = 0;
    logic              expReadyNow = 1'b0;
    logic [FLAG_W-1:0] expArch = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against model state as it stood before this cycle's edge.
    always @(negedge clk) begin
        bundleT b;
        logic   ev;
        if (reset) begin
            q.delete();
            expArch     = '0;
            expReadyNow = 1'b0;
        end else begin
            ev          = (q.size() != 0) && !flush;
            expReadyNow = (q.size() != 2) && !flush;
            chk("in_ready", 128'(in_ready), 128'(expReadyNow));
            chk("out_valid", 128'(out_valid), 128'(ev));
            chk("count", 128'(count), 128'(q.size()));
            chk("arch_flags", 128'(arch_flags), 128'(expArch));
            b = ev ? q[0] : '0;
            chk("out_rd", 128'(out_rd), 128'(b.rd));
            chk("out_data", 128'(out_data), 128'(b.data));
            chk("out_regwrite", 128'(out_regwrite), 128'(b.rw));
            chk("out_flags", 128'(out_flags), 128'(b.flags));
            chk("out_flagwrite", 128'(out_flagwrite), 128'(b.fw));
            if (flush) begin
                q.delete();
            end else if (ev && out_ready) begin
                b = q.pop_front();
                for (int i = 0; i < int'(LANES); i++) begin
                    if (b.fw[i]) expArch = b.flags[i*FLAG_W +: FLAG_W];
                end
            end
        end
    end

    // Driver-side scoreboard push: the model decides whether the offer is taken.
    always @(negedge clk) begin
        #2;
        if (!reset && in_valid && expReadyNow) begin
            q.push_back('{rd: in_rd, data: in_data, rw: in_regwrite, flags: in_flags,
                          fw: in_flagwrite});
            pushCnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setB(input logic [LANES*REG_AW-1:0] rd, input logic [LANES*DATA_W-1:0] d,
                        input logic [LANES-1:0] rw, input logic [LANES*FLAG_W-1:0] f,
                        input logic [LANES-1:0] fw);
        in_rd        = rd;
        in_data      = d;
        in_regwrite  = rw;
        in_flags     = f;
        in_flagwrite = fw;
    endtask

    task automatic setRand();
        setB(LANES*REG_AW'($urandom), {$urandom, $urandom}, LANES'($urandom),
             (LANES*FLAG_W)'($urandom), LANES'($urandom));
    endtask

    initial begin
        int startCnt;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        setB('0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("reset_ready", 128'(in_ready), 128'(1));
        chk("reset_count", 128'(count), 128'(0));

        // Single bundle
        setB({3'd5, 3'd3}, {32'h1234, 32'hDEADBEEF}, 2'b01, '0, 2'b00);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 128'(out_valid), 128'(1));
        chk("single_rw", 128'(out_regwrite), 128'(2'b01));
        chk("single_data", 128'(out_data), 128'({32'h1234, 32'hDEADBEEF}));
        step();
        chk("single_drain", 128'(count), 128'(0));

        // Backpressure: B0, B1 absorbed, B2 held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setB(6'(i + 1), {32'(i), 32'hB0B0_0000 + 32'(i)}, 2'b11, 8'(i), 2'b00);
            step();
        end
        step();
        chk("bp_ready", 128'(in_ready), 128'(0));
        chk("bp_count", 128'(count), 128'(2));
        startCnt  = pushCnt;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && pushCnt == startCnt; i++) step();
        chk("bp_b2_taken", 128'(pushCnt - startCnt), 128'(1));
        in_valid = 1'b0;
        repeat (4) step();

        // Flag ordering: highest lane wins, no writer holds
        setB('0, '0, '0, {4'b0110, 4'b1000}, 2'b11);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("flags_order", 128'(arch_flags), 128'(4'b0110));
        setB('0, '0, '0, {4'b1111, 4'b1111}, 2'b00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("flags_hold", 128'(arch_flags), 128'(4'b0110));

        // Flush with two held and a third offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            setRand();
            step();
        end
        setB('1, '1, '1, '1, '1);
        flush = 1'b1;
        #1;
        chk("flush_ready", 128'(in_ready), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_arch", 128'(arch_flags), 128'(4'b0110));
        out_ready = 1'b1;
        repeat (3) step();

        // Streaming at full throughput
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            setB('0, {32'h0, 32'(i)}, 2'b01, '0, '0);
            step();
            chk("stream_count", 128'(count), 128'(1));
            chk("stream_data", 128'(out_data[DATA_W-1:0]), 128'(i));
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            setRand();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            step();
        end
        flush = 1'b0;

        // Reset together with flush
        in_valid = 1'b1;
        step();
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("rst_flush_count", 128'(count), 128'(0));
        chk("rst_flush_arch", 128'(arch_flags), 128'(0));
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
